// File: rtl/pipe_stage_reg_if.sv
// Pipeline-boundary bundle: stage controls, incoming slot fields and registered outputs.
// master drives the slot and controls; slave is the pipe_stage_reg instance.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned TNEW_W    = 3,
    parameter int unsigned CNT_W     = 16
);
    logic                 hold;
    logic                 bubble;
    logic                 flush;
    logic                 cnt_clear;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_pc;
    logic [31:0]          in_instr;
    logic [DATA_W-1:0]    in_rd1;
    logic [DATA_W-1:0]    in_rd2;
    logic [DATA_W-1:0]    in_imm;
    logic [4:0]           in_a1;
    logic [4:0]           in_a2;
    logic [4:0]           in_a3;
    logic                 in_regwrite;
    logic [TNEW_W-1:0]    in_tnew;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic [DATA_W-1:0]    out_pc;
    logic [DATA_W-1:0]    out_pc8;
    logic [31:0]          out_instr;
    logic [DATA_W-1:0]    out_rd1;
    logic [DATA_W-1:0]    out_rd2;
    logic [DATA_W-1:0]    out_imm;
    logic [4:0]           out_a1;
    logic [4:0]           out_a2;
    logic [4:0]           out_a3;
    logic                 out_regwrite;
    logic [TNEW_W-1:0]    out_tnew;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     cnt_instr;
    logic [CNT_W-1:0]     cnt_bubble;

    modport master (
        output hold, bubble, flush, cnt_clear,
        output in_valid, in_pc, in_instr, in_rd1, in_rd2, in_imm,
        output in_a1, in_a2, in_a3, in_regwrite, in_tnew, in_payload,
        input  out_valid, out_pc, out_pc8, out_instr, out_rd1, out_rd2, out_imm,
        input  out_a1, out_a2, out_a3, out_regwrite, out_tnew, out_payload,
        input  cnt_instr, cnt_bubble
    );

    modport slave (
        input  hold, bubble, flush, cnt_clear,
        input  in_valid, in_pc, in_instr, in_rd1, in_rd2, in_imm,
        input  in_a1, in_a2, in_a3, in_regwrite, in_tnew, in_payload,
        output out_valid, out_pc, out_pc8, out_instr, out_rd1, out_rd2, out_imm,
        output out_a1, out_a2, out_a3, out_regwrite, out_tnew, out_payload,
        output cnt_instr, cnt_bubble
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold/bubble/flush, valid bit, PC+8,
// optional Tnew decrement and saturating instruction/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned TNEW_W    = 3,
    parameter bit          DEC_TNEW  = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    pipe_stage_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 valid_q,    valid_d;
    logic [DATA_W-1:0]    pc_q,       pc_d;
    logic [DATA_W-1:0]    pc8_q,      pc8_d;
    logic [31:0]          instr_q,    instr_d;
    logic [DATA_W-1:0]    rd1_q,      rd1_d;
    logic [DATA_W-1:0]    rd2_q,      rd2_d;
    logic [DATA_W-1:0]    imm_q,      imm_d;
    logic [4:0]           a1_q,       a1_d;
    logic [4:0]           a2_q,       a2_d;
    logic [4:0]           a3_q,       a3_d;
    logic                 regwrite_q, regwrite_d;
    logic [TNEW_W-1:0]    tnew_q,     tnew_d;
    logic [PAYLOAD_W-1:0] payload_q,  payload_d;
    logic [CNT_W-1:0]     cnt_instr_q,  cnt_instr_d;
    logic [CNT_W-1:0]     cnt_bubble_q, cnt_bubble_d;
    logic                 clear_c;
    logic                 load_c;

    // Priority: flush > hold > bubble > load; hold is the default (keep contents).
    always_comb begin
        clear_c      = 1'b0;
        load_c       = 1'b0;
        valid_d      = valid_q;
        pc_d         = pc_q;
        pc8_d        = pc8_q;
        instr_d      = instr_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        a3_d         = a3_q;
        regwrite_d   = regwrite_q;
        tnew_d       = tnew_q;
        payload_d    = payload_q;
        cnt_instr_d  = cnt_instr_q;
        cnt_bubble_d = cnt_bubble_q;

        if (bus.flush) begin
            clear_c = 1'b1;
        end else if (!bus.hold) begin
            if (bus.bubble) begin
                clear_c = 1'b1;
                if (cnt_bubble_q != CNT_MAX) cnt_bubble_d = cnt_bubble_q + CNT_W'(1);
            end else begin
                load_c = 1'b1;
                if (bus.in_valid && cnt_instr_q != CNT_MAX) cnt_instr_d = cnt_instr_q + CNT_W'(1);
            end
        end

        if (clear_c) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            pc8_d      = '0;
            instr_d    = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            a1_d       = '0;
            a2_d       = '0;
            a3_d       = '0;
            regwrite_d = 1'b0;
            tnew_d     = '0;
            payload_d  = '0;
        end else if (load_c) begin
            valid_d    = bus.in_valid;
            pc_d       = bus.in_pc;
            pc8_d      = bus.in_pc + DATA_W'(8);
            instr_d    = bus.in_instr;
            rd1_d      = bus.in_rd1;
            rd2_d      = bus.in_rd2;
            imm_d      = bus.in_imm;
            a1_d       = bus.in_a1;
            a2_d       = bus.in_a2;
            // An empty slot must never produce a forwarding/stall match.
            a3_d       = bus.in_valid ? bus.in_a3 : 5'd0;
            regwrite_d = bus.in_valid & bus.in_regwrite;
            payload_d  = bus.in_payload;
            if (DEC_TNEW) begin
                tnew_d = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TNEW_W'(1);
            end else begin
                tnew_d = bus.in_tnew;
            end
        end

        if (bus.cnt_clear) begin
            cnt_instr_d  = '0;
            cnt_bubble_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            pc8_q        <= '0;
            instr_q      <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            a3_q         <= '0;
            regwrite_q   <= 1'b0;
            tnew_q       <= '0;
            payload_q    <= '0;
            cnt_instr_q  <= '0;
            cnt_bubble_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            pc8_q        <= pc8_d;
            instr_q      <= instr_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            a3_q         <= a3_d;
            regwrite_q   <= regwrite_d;
            tnew_q       <= tnew_d;
            payload_q    <= payload_d;
            cnt_instr_q  <= cnt_instr_d;
            cnt_bubble_q <= cnt_bubble_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_pc8      = pc8_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_rd1      = rd1_q;
    assign bus.out_rd2      = rd2_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_a1       = a1_q;
    assign bus.out_a2       = a2_q;
    assign bus.out_a3       = a3_q;
    assign bus.out_regwrite = regwrite_q;
    assign bus.out_tnew     = tnew_q;
    assign bus.out_payload  = payload_q;
    assign bus.cnt_instr    = cnt_instr_q;
    assign bus.cnt_bubble   = cnt_bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default; CNT_W=4 with Tnew pass-through)
// share stimulus and are checked against a reference model through a scoreboard queue.
module tb_pipe_stage_reg;
    typedef struct packed {
        logic        hold, bubble, flush, clr, valid;
        logic [31:0] pc, instr, rd1, rd2, imm;
        logic [4:0]  a1, a2, a3;
        logic        rw;
        logic [2:0]  tnew;
        logic [63:0] payload;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, pc8, instr, rd1, rd2, imm;
        logic [4:0]  a1, a2, a3;
        logic        rw;
        logic [2:0]  tnew;
        logic [63:0] payload;
        logic [15:0] ci, cb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if                  if0 ();
    pipe_stage_reg_if #(.CNT_W(4))     if1 ();

    pipe_stage_reg dut0 (.clk(clk), .reset(reset), .bus(if0));
    pipe_stage_reg #(.DEC_TNEW(1'b0), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    assign if1.hold        = if0.hold;
    assign if1.bubble      = if0.bubble;
    assign if1.flush       = if0.flush;
    assign if1.cnt_clear   = if0.cnt_clear;
    assign if1.in_valid    = if0.in_valid;
    assign if1.in_pc       = if0.in_pc;
    assign if1.in_instr    = if0.in_instr;
    assign if1.in_rd1      = if0.in_rd1;
    assign if1.in_rd2      = if0.in_rd2;
    assign if1.in_imm      = if0.in_imm;
    assign if1.in_a1       = if0.in_a1;
    assign if1.in_a2       = if0.in_a2;
    assign if1.in_a3       = if0.in_a3;
    assign if1.in_regwrite = if0.in_regwrite;
    assign if1.in_tnew     = if0.in_tnew;
    assign if1.in_payload  = if0.in_payload;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input int cw);
        logic [16:0] lim;
        lim = (17'd1 << cw) - 17'd1;
        return ({1'b0, v} >= lim) ? v : v + 16'd1;
    endfunction

    function automatic exp_t model(input exp_t c, input stim_t s, input bit rst,
                                   input bit dec, input int cw);
        exp_t n;
        n = c;
        if (rst) return '0;
        if (s.flush || (!s.hold && s.bubble)) begin
            n    = '0;
            n.ci = c.ci;
            n.cb = (!s.flush) ? sat_inc(c.cb, cw) : c.cb;
        end else if (!s.hold) begin
            n.valid   = s.valid;
            n.pc      = s.pc;
            n.pc8     = s.pc + 32'd8;
            n.instr   = s.instr;
            n.rd1     = s.rd1;
            n.rd2     = s.rd2;
            n.imm     = s.imm;
            n.a1      = s.a1;
            n.a2      = s.a2;
            n.a3      = s.valid ? s.a3 : 5'd0;
            n.rw      = s.valid ? s.rw : 1'b0;
            n.tnew    = !dec ? s.tnew : ((s.tnew == 3'd0) ? 3'd0 : s.tnew - 3'd1);
            n.payload = s.payload;
            if (s.valid) n.ci = sat_inc(c.ci, cw);
        end
        if (s.clr) begin
            n.ci = '0;
            n.cb = '0;
        end
        return n;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s         = '0;
        s.valid   = 1'b1;
        s.pc      = $urandom & 32'hffff_fffc;
        s.instr   = $urandom;
        s.rd1     = $urandom;
        s.rd2     = $urandom;
        s.imm     = $urandom;
        s.a1      = 5'($urandom);
        s.a2      = 5'($urandom);
        s.a3      = 5'($urandom);
        s.rw      = 1'($urandom);
        s.tnew    = 3'($urandom);
        s.payload = {$urandom, $urandom};
        return s;
    endfunction

    task automatic compare(input string who, input exp_t o, input exp_t e);
        check({who, ".valid"},   64'(o.valid),   64'(e.valid));
        check({who, ".pc"},      64'(o.pc),      64'(e.pc));
        check({who, ".pc8"},     64'(o.pc8),     64'(e.pc8));
        check({who, ".instr"},   64'(o.instr),   64'(e.instr));
        check({who, ".rd1"},     64'(o.rd1),     64'(e.rd1));
        check({who, ".rd2"},     64'(o.rd2),     64'(e.rd2));
        check({who, ".imm"},     64'(o.imm),     64'(e.imm));
        check({who, ".a1"},      64'(o.a1),      64'(e.a1));
        check({who, ".a2"},      64'(o.a2),      64'(e.a2));
        check({who, ".a3"},      64'(o.a3),      64'(e.a3));
        check({who, ".rw"},      64'(o.rw),      64'(e.rw));
        check({who, ".tnew"},    64'(o.tnew),    64'(e.tnew));
        check({who, ".payload"}, o.payload,      e.payload);
        check({who, ".cnt_instr"},  64'(o.ci),   64'(e.ci));
        check({who, ".cnt_bubble"}, 64'(o.cb),   64'(e.cb));
    endtask

    // One clock: drive, push the predicted outputs, then pop and compare after the edge.
    task automatic step(input stim_t s, input bit rst);
        exp_t o, e;
        reset          = rst;
        if0.hold       = s.hold;
        if0.bubble     = s.bubble;
        if0.flush      = s.flush;
        if0.cnt_clear  = s.clr;
        if0.in_valid   = s.valid;
        if0.in_pc      = s.pc;
        if0.in_instr   = s.instr;
        if0.in_rd1     = s.rd1;
        if0.in_rd2     = s.rd2;
        if0.in_imm     = s.imm;
        if0.in_a1      = s.a1;
        if0.in_a2      = s.a2;
        if0.in_a3      = s.a3;
        if0.in_regwrite = s.rw;
        if0.in_tnew    = s.tnew;
        if0.in_payload = s.payload;
        m0 = model(m0, s, rst, 1'b1, 16);
        m1 = model(m1, s, rst, 1'b0, 4);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        check("sb_nonempty", 64'(q0.size() != 0 && q1.size() != 0), 64'(1));
        if (q0.size() != 0 && q1.size() != 0) begin
            e = q0.pop_front();
            o = '{if0.out_valid, if0.out_pc, if0.out_pc8, if0.out_instr, if0.out_rd1,
                  if0.out_rd2, if0.out_imm, if0.out_a1, if0.out_a2, if0.out_a3,
                  if0.out_regwrite, if0.out_tnew, if0.out_payload,
                  if0.cnt_instr, if0.cnt_bubble};
            compare("dut0", o, e);
            e = q1.pop_front();
            o = '{if1.out_valid, if1.out_pc, if1.out_pc8, if1.out_instr, if1.out_rd1,
                  if1.out_rd2, if1.out_imm, if1.out_a1, if1.out_a2, if1.out_a3,
                  if1.out_regwrite, if1.out_tnew, if1.out_payload,
                  16'(if1.cnt_instr), 16'(if1.cnt_bubble)};
            compare("dut1", o, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        m0 = '0;
        m1 = '0;
        @(negedge clk);
        s = rand_stim();
        step(s, 1'b1);
        step(s, 1'b1);

        // Fill with nonzero contents, then reset with every control asserted.
        repeat (4) begin
            s = rand_stim();
            step(s, 1'b0);
        end
        s = rand_stim();
        s.hold = 1'b1; s.bubble = 1'b1; s.flush = 1'b1;
        step(s, 1'b1);
        check("rst_pc",     64'(if0.out_pc),     64'(0));
        check("rst_cnt_i",  64'(if0.cnt_instr),  64'(0));
        check("rst_cnt_b",  64'(if0.cnt_bubble), 64'(0));

        // Load with Tnew decrement and PC+8.
        s = rand_stim();
        s.pc = 32'h0000_3000; s.tnew = 3'd2;
        step(s, 1'b0);
        check("ld_pc8",    64'(if0.out_pc8),   64'h3008);
        check("ld_tnew",   64'(if0.out_tnew),  64'(1));
        check("ld_tnew_pt", 64'(if1.out_tnew), 64'(2));
        check("ld_cnt_i",  64'(if0.cnt_instr), 64'(1));
        s = rand_stim();
        s.tnew = 3'd0;
        step(s, 1'b0);
        check("ld_tnew0",  64'(if0.out_tnew),  64'(0));

        // Hold three cycles, then a bubble.
        s = rand_stim();
        s.a3 = 5'd5; s.rw = 1'b1; s.tnew = 3'd2;
        step(s, 1'b0);
        repeat (3) begin
            s = rand_stim();
            s.hold = 1'b1;
            step(s, 1'b0);
        end
        check("hold_tnew", 64'(if0.out_tnew),     64'(1));
        check("hold_a3",   64'(if0.out_a3),       64'(5));
        check("hold_rw",   64'(if0.out_regwrite), 64'(1));
        s = rand_stim();
        s.bubble = 1'b1;
        step(s, 1'b0);
        check("bub_a3",    64'(if0.out_a3),       64'(0));
        check("bub_rw",    64'(if0.out_regwrite), 64'(0));
        check("bub_cnt",   64'(if0.cnt_bubble),   64'(1));

        // Priority: flush+hold+bubble, then hold+bubble.
        s = rand_stim();
        step(s, 1'b0);
        s = rand_stim();
        s.flush = 1'b1; s.hold = 1'b1; s.bubble = 1'b1;
        step(s, 1'b0);
        check("fl_valid",  64'(if0.out_valid),  64'(0));
        check("fl_cnt_b",  64'(if0.cnt_bubble), 64'(1));
        s = rand_stim();
        s.a3 = 5'd9;
        step(s, 1'b0);
        s = rand_stim();
        s.hold = 1'b1; s.bubble = 1'b1;
        step(s, 1'b0);
        check("hb_a3",     64'(if0.out_a3),     64'(9));
        check("hb_cnt_b",  64'(if0.cnt_bubble), 64'(1));

        // Invalid slot.
        s = rand_stim();
        s.valid = 1'b0; s.rw = 1'b1; s.a3 = 5'd31;
        step(s, 1'b0);
        check("inv_rw",    64'(if0.out_regwrite), 64'(0));
        check("inv_a3",    64'(if0.out_a3),       64'(0));

        // Counter saturation on the 4-bit instance, then clear with a load.
        repeat (20) begin
            s = rand_stim();
            step(s, 1'b0);
        end
        check("sat_cnt_i", 64'(if1.cnt_instr), 64'(15));
        s = rand_stim();
        s.clr = 1'b1;
        step(s, 1'b0);
        check("clr_cnt_i", 64'(if1.cnt_instr), 64'(0));
        check("clr_valid", 64'(if1.out_valid), 64'(1));
        repeat (20) begin
            s = rand_stim();
            s.bubble = 1'b1;
            step(s, 1'b0);
        end
        check("sat_cnt_b", 64'(if1.cnt_bubble), 64'(15));

        // Mid-operation reset while held, then resume.
        s = rand_stim();
        s.hold = 1'b1;
        step(s, 1'b1);
        s = rand_stim();
        s.pc = 32'hffff_fffc;
        step(s, 1'b0);
        check("wrap_pc8", 64'(if0.out_pc8), 64'h4);

        // Random mix of controls.
        for (int i = 0; i < 250; i++) begin
            s        = rand_stim();
            s.hold   = ($urandom_range(0, 99) < 15);
            s.bubble = ($urandom_range(0, 9) == 0);
            s.flush  = ($urandom_range(0, 19) == 0);
            s.clr    = ($urandom_range(0, 29) == 0);
            s.valid  = ($urandom_range(0, 5) != 0);
            step(s, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
